// File: rtl/reg_file_sequencer_if.sv
// reg_file_sequencer_if: instruction handshake plus register-file select/data bus.
interface reg_file_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              instr_valid;
  logic [7:0]        instr;
  logic              instr_ready;
  logic [ADDR_W-1:0] rf_in_1;
  logic [ADDR_W-1:0] rf_in_2;
  logic              rf_wen;
  logic [DATA_W-1:0] rf_data;
  logic [DATA_W-1:0] rf_out_1;
  logic [DATA_W-1:0] rf_out_2;
  modport master (
    input  instr_valid, instr, rf_out_1, rf_out_2,
    output instr_ready, rf_in_1, rf_in_2, rf_wen, rf_data
  );
  modport slave (
    output instr_valid, instr, rf_out_1, rf_out_2,
    input  instr_ready, rf_in_1, rf_in_2, rf_wen, rf_data
  );
endinterface

// File: rtl/reg_file_sequencer.sv
// reg_file_sequencer: multi-cycle sequencer driving a 4x8 register file with ALU and Z/C/N flags.
module reg_file_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic clk,
  input  logic rst,
  reg_file_sequencer_if.master bus,
  output logic flag_z,
  output logic flag_c,
  output logic flag_n,
  output logic busy,
  output logic illegal
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] IMM  = 3'd1;
  localparam logic [2:0] READ = 3'd2;
  localparam logic [2:0] EXEC = 3'd3;
  localparam logic [2:0] WB   = 3'd4;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  logic [2:0]        state_q, state_d;
  logic [7:0]        ir_q, ir_d;
  logic [DATA_W-1:0] a_q, b_q, res_q, res_d;
  logic              z_q, z_d, c_q, c_d, n_q, n_d;
  logic              ill_q, ill_d, rdy_q, rdy_d;
  logic [3:0]        op, in_op;
  logic              acc;
  logic [DATA_W:0]   alu;
  assign op    = ir_q[7:4];
  assign in_op = bus.instr[7:4];
  assign acc   = bus.instr_valid && rdy_q;
  // Bit DATA_W of alu is the carry/borrow/shifted-out bit; MOV carries the old C through.
  always_comb begin
    alu = {c_q, b_q};
    case (op)
      4'h2:         alu = {1'b0, a_q} + {1'b0, b_q};
      4'h3, OP_CMP: alu = {1'b0, a_q} - {1'b0, b_q};
      4'h4:         alu = {1'b0, a_q & b_q};
      4'h5:         alu = {1'b0, a_q | b_q};
      4'h6:         alu = {1'b0, a_q ^ b_q};
      4'h7:         alu = {1'b0, ~b_q};
      4'h8:         alu = {a_q[DATA_W-1], a_q[DATA_W-2:0], 1'b0};
      4'h9:         alu = {a_q[0], 1'b0, a_q[DATA_W-1:1]};
      default:      alu = {c_q, b_q};
    endcase
  end
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
    ill_d   = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        ir_d    = bus.instr;
        ill_d   = in_op >= 4'hC;
        state_d = in_op == OP_LDI ? IMM : (in_op == 4'h0 || in_op >= 4'hC) ? IDLE : READ;
      end
      IMM: if (acc) begin
        res_d   = bus.instr;
        z_d     = bus.instr == 8'h00;
        n_d     = bus.instr[7];
        state_d = WB;
      end
      READ: state_d = EXEC;
      EXEC: begin
        z_d     = alu[DATA_W-1:0] == '0;
        n_d     = alu[DATA_W-1];
        c_d     = alu[DATA_W];
        res_d   = op == OP_CMP ? res_q : alu[DATA_W-1:0];
        state_d = op == OP_CMP ? IDLE : WB;
      end
      default: state_d = IDLE;
    endcase
  end
  assign rdy_d = state_d == IDLE || state_d == IMM;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      ill_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= state_q == READ ? bus.rf_out_1 : a_q;
      b_q     <= state_q == READ ? bus.rf_out_2 : b_q;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
      ill_q   <= ill_d;
      rdy_q   <= rdy_d;
    end
  end
  // Write enable is decoded from state so reset removes it without waiting for an edge.
  assign bus.rf_wen      = state_q == WB;
  assign bus.rf_in_1     = (state_q == READ || state_q == WB) ? ir_q[3:2] : '0;
  assign bus.rf_in_2     = state_q == READ ? ir_q[1:0] : '0;
  assign bus.rf_data     = res_q;
  assign bus.instr_ready = rdy_q;
  assign flag_z          = z_q;
  assign flag_c          = c_q;
  assign flag_n          = n_q;
  assign busy            = state_q != IDLE;
  assign illegal         = ill_q;
endmodule

// File: tb/tb_reg_file_sequencer.sv
// tb_reg_file_sequencer: directed vectors against a behavioural 4x8 register file.
module tb_reg_file_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flag_z, flag_c, flag_n, busy, illegal;
  logic [7:0] regs [4];
  int n_tests = 0;
  int n_fail = 0;
  reg_file_sequencer_if #(.DATA_W(8), .ADDR_W(2)) bus ();
  reg_file_sequencer #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .busy(busy), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign bus.rf_out_1 = regs[bus.rf_in_1];
  assign bus.rf_out_2 = regs[bus.rf_in_2];
  always @(posedge clk) if (bus.rf_wen) regs[bus.rf_in_1] <= bus.rf_data;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = b;
    while (!bus.instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
  endtask
  task automatic ldi(input logic [1:0] rd, input logic [7:0] v);
    send({4'hA, rd, 2'b00});
    check("ldi_busy", busy, 1);
    send(v);
    check("ldi_wen", bus.rf_wen, 1);
    check("ldi_addr", bus.rf_in_1, rd);
    check("ldi_data", bus.rf_data, v);
    @(posedge clk);
    #1 check("ldi_wen_drop", bus.rf_wen, 0);
  endtask
  // Flags packed as {Z,C,N}; write must be visible in the E2-E3 cycle only.
  task automatic alu_op(input string tag, input logic [7:0] ins, input logic [7:0] exp, input logic [2:0] zcn);
    check({tag, "_rdy0"}, bus.instr_ready, 0);
    check({tag, "_sel2"}, bus.rf_in_2, ins[1:0]);
    @(posedge clk);
    #1 check({tag, "_exec_wen"}, bus.rf_wen, 0);
    @(posedge clk);
    #1 check({tag, "_wen"}, bus.rf_wen, 1);
    check({tag, "_addr"}, bus.rf_in_1, ins[3:2]);
    check({tag, "_data"}, bus.rf_data, exp);
    check({tag, "_flags"}, {flag_z, flag_c, flag_n}, zcn);
    @(posedge clk);
    #1 check({tag, "_wen_drop"}, bus.rf_wen, 0);
    check({tag, "_rdy1"}, bus.instr_ready, 1);
  endtask
  task automatic run_op(input string tag, input logic [7:0] ins, input logic [7:0] exp, input logic [2:0] zcn);
    send(ins);
    alu_op(tag, ins, exp, zcn);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic seen;
    for (int i = 0; i < 4; i++) regs[i] = 8'h00;
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    repeat (3) @(posedge clk);
    #1 check("rst_rdy", bus.instr_ready, 0);
    check("rst_wen", bus.rf_wen, 0);
    check("rst_flags", {flag_z, flag_c, flag_n}, 3'b000);
    check("rst_busy_ill", {busy, illegal}, 2'b00);
    check("rst_bus", {bus.rf_in_1, bus.rf_in_2, bus.rf_data}, 12'h000);
    @(negedge clk) rst = 1'b1;
    #1 check("rel_rdy_pre", bus.instr_ready, 0);
    @(posedge clk);
    #1 check("rel_rdy", bus.instr_ready, 1);
    ldi(2'd1, 8'h7F);
    check("ldi_flags", {flag_z, flag_c, flag_n}, 3'b000);
    ldi(2'd2, 8'h01);
    run_op("add", 8'h26, 8'h80, 3'b001);
    ldi(2'd0, 8'h00);
    check("ldi0_flags", {flag_z, flag_c, flag_n}, 3'b100);
    ldi(2'd3, 8'h01);
    run_op("sub", 8'h33, 8'hFF, 3'b011);
    send(8'hBF);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= bus.rf_wen;
      @(posedge clk);
      #1;
    end
    check("cmp_nowen", seen, 0);
    check("cmp_flags", {flag_z, flag_c, flag_n}, 3'b100);
    check("cmp_idle", {busy, bus.instr_ready}, 2'b01);
    ldi(2'd2, 8'h81);
    run_op("shl", 8'h88, 8'h02, 3'b010);
    run_op("shr", 8'h98, 8'h01, 3'b000);
    run_op("xor", 8'h61, 8'h7F, 3'b000);
    run_op("and", 8'h43, 8'h01, 3'b000);
    run_op("or", 8'h56, 8'h81, 3'b001);
    run_op("not", 8'h7D, 8'h7E, 3'b000);
    run_op("add_c", 8'h25, 8'h02, 3'b010);
    run_op("mov", 8'h1B, 8'h7E, 3'b010);
    send(8'hE5);
    check("ill_pulse", illegal, 1);
    check("ill_idle", {busy, bus.instr_ready, bus.rf_wen}, 3'b010);
    @(posedge clk);
    #1 check("ill_drop", illegal, 0);
    check("ill_flags", {flag_z, flag_c, flag_n}, 3'b010);
    send(8'h00);
    check("nop_idle", {busy, bus.instr_ready, bus.rf_wen, illegal}, 4'b0100);
    check("nop_flags", {flag_z, flag_c, flag_n}, 3'b010);
    send(8'h21);
    @(posedge clk);
    @(posedge clk);
    #1 check("rwb_wen", bus.rf_wen, 1);
    check("rwb_data", bus.rf_data, 8'h03);
    rst = 1'b0;
    #1 check("rwb_wen_async", bus.rf_wen, 0);
    check("rwb_busy", busy, 0);
    check("rwb_rdy", bus.instr_ready, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check("rwb_rdy_rel", bus.instr_ready, 1);
    check("rwb_flags", {flag_z, flag_c, flag_n}, 3'b000);
    run_op("post_rst_add", 8'h20, 8'h02, 3'b000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_sequencer.md
Name: reg_file_sequencer

Overview:
Multi-cycle control sequencer that sits in front of the 4x8 register file and acts as its initiator. It accepts 8-bit instructions over a valid/ready handshake and drives the file's two address selects. It reads both operands, computes an ALU result, and issues a single write-enable pulse for writeback. It also maintains Z/C/N status flags and flags illegal opcodes.

Parameters:
DATA_W, 8, datapath and register width; only 8 is supported.
ADDR_W, 2, register-select width, giving 4 registers; only 2 is supported.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction byte present on instr
instr  input  8  instruction byte, or immediate byte for the second beat of LDI
instr_ready  output  1  sequencer can accept a byte; transfer occurs when valid&&ready at a rising edge
rf_in_1  output  2  register file select 1; read select and write address
rf_in_2  output  2  register file select 2; read select
rf_wen  output  1  register file write enable
rf_data  output  8  register file write data
rf_out_1  input  8  register file read data for rf_in_1
rf_out_2  input  8  register file read data for rf_in_2
flag_z  output  1  last result was zero
flag_c  output  1  carry/borrow/shifted-out bit
flag_n  output  1  last result bit 7
busy  output  1  state is not IDLE
illegal  output  1  one-cycle pulse on an illegal opcode

Behaviour:
- Instruction format: [7:4] op, [3:2] rd (also source A), [1:0] rs (source B).
- Opcodes: 0 NOP, 1 MOV rd<=rs, 2 ADD, 3 SUB (rd-rs), 4 AND, 5 OR, 6 XOR, 7 NOT rd<=~rs, 8 SHL rd<=rd<<1, 9 SHR rd<=rd>>1 (logical), A LDI rd<=next byte, B CMP (rd-rs, flags only). C-F are illegal.
- States: IDLE, IMM, READ, EXEC, WB.
- Reset (rst=0): state goes to IDLE immediately. All outputs are 0, including instr_ready, rf_wen, flags and illegal. instr_ready is registered and rises on the first clock edge after rst releases.
- Reset mid-operation: rf_wen drops asynchronously and the pending writeback is discarded. No partial write is allowed.
- IDLE: instr_ready=1.
  - Accepted NOP: stays in IDLE; flags unchanged.
  - Accepted illegal opcode: stays in IDLE; illegal=1 for the next cycle; flags unchanged; no write.
  - Accepted LDI: goes to IMM.
  - All other opcodes: go to READ with instr_ready=0; the instruction is latched.
- IMM: instr_ready=1 and waits indefinitely. The accepted byte becomes the result; Z and N are updated, C is held; next state is WB.
- READ: rf_in_1=rd, rf_in_2=rs. Operands are sampled at the edge; next state is EXEC.
- EXEC: result and flags are registered at the edge. CMP then goes to IDLE; all other ops go to WB.
- WB: rf_wen=1, rf_in_1=rd, rf_data=result for exactly one cycle. Next state is IDLE.
- Outside READ and WB: rf_in_1=rf_in_2=0, rf_data holds the last result, rf_wen=0.
- Latency from accept edge E0:
  - Register ops: READ during E0-E1, EXEC during E1-E2, WB during E2-E3; file updated at E3; instr_ready=1 again after E3.
  - Throughput is 1 instruction per 4 cycles.
  - LDI: write happens 1 cycle after the immediate byte is accepted.
- Arithmetic (modulo 256):
  - ADD: C=carry out.
  - SUB/CMP: C=1 when rd<rs (borrow).
  - SHL: C=old bit7.
  - SHR: C=old bit0.
  - AND/OR/XOR/NOT: C=0.
  - MOV: C held.
  - Z=(result==0), N=result[7] for every flag-updating op.
- rd==rs is legal: both selects address the same register and read the same value.
- instr_valid deasserted: the sequencer stays in IDLE/IMM with no side effects. instr is ignored whenever instr_ready=0.

Test Plan:
- Reset release: rst low, then high. Expected: all outputs 0 during reset; instr_ready=1 one edge after release.
- LDI: LDI r1,0x7F; LDI r2,0x01; ADD r1,r2. Expected: rf_wen pulses with rf_in_1=1 and rf_data=0x80; N=1, Z=0, C=0.
- SUB wrap: r0=0x00, r3=0x01; SUB r0,r3. Expected: rf_data=0xFF, C=1, N=1. Then CMP r3,r3: Z=1, C=0, and rf_wen never asserts.
- Shifts: r2=0x81. SHL r2: 0x02, C=1. SHR r2: 0x01, C=0. Check that each write lands exactly 3 cycles after accept.
- Illegal/NOP: opcode 0xE5 gives an illegal pulse for 1 cycle with no rf_wen and flags unchanged. 0x00 is accepted with ready held at 1.
- Reset in WB: drop rst during the rf_wen cycle of ADD. Expected: rf_wen falls immediately, no write, state IDLE after release.
